// File: rtl/cdb_tag_scheduler.sv
// cdb_tag_scheduler: round-robin scheduling of FU result tags onto CDB slots.
// One pending entry per FU; broadcast slot outputs are registered.
module cdb_tag_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_TAG  = 3,
  parameter int TAG_SIZE = 6
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               flush,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0][TAG_SIZE-1:0]   req_tag,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [NUM_TAG-1:0]                 cdb_enable,
  output logic [NUM_TAG-1:0][TAG_SIZE-1:0]   cdb_tag
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]               pend_valid;
  logic [NUM_REQ-1:0][TAG_SIZE-1:0] pend_tag;
  logic [PW-1:0]                    rr_ptr;

  logic [NUM_REQ-1:0]               grant;
  logic [NUM_REQ-1:0]               accept;
  logic [NUM_TAG-1:0]               slot_en;
  logic [NUM_TAG-1:0][TAG_SIZE-1:0] slot_tag;
  logic [PW-1:0]                    rr_nxt;

  // Scan from rr_ptr; the n-th pending entry found lands in slot n.
  always_comb begin : select
    int cnt;
    int idx;
    grant    = '0;
    slot_en  = '0;
    slot_tag = '0;
    rr_nxt   = rr_ptr;
    cnt      = 0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ)
        idx = idx - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == idx && pend_valid[i] && cnt < NUM_TAG) begin
          grant[i] = 1'b1;
          for (int j = 0; j < NUM_TAG; j++) begin
            if (j == cnt) begin
              slot_en[j]  = 1'b1;
              slot_tag[j] = pend_tag[i];
            end
          end
          cnt = cnt + 1;
          if (i == NUM_REQ - 1)
            rr_nxt = '0;
          else
            rr_nxt = PW'(i + 1);
        end
      end
    end
  end

  assign req_ready = {NUM_REQ{reset & ~flush}}
                   & (~pend_valid | grant);
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      pend_valid <= '0;
      rr_ptr     <= '0;
      cdb_enable <= '0;
      cdb_tag    <= '0;
    end else if (flush) begin
      pend_valid <= '0;
      cdb_enable <= '0;
      cdb_tag    <= '0;
    end else begin
      pend_valid <= accept | (pend_valid & ~grant);
      rr_ptr     <= rr_nxt;
      cdb_enable <= slot_en;
      cdb_tag    <= slot_tag;
    end
  end

  // Tag payload needs no reset; validity lives in pend_valid.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i])
        pend_tag[i] <= req_tag[i];
    end
  end

endmodule

// File: tb/tb_cdb_tag_scheduler.sv
// tb_cdb_tag_scheduler: vector table plus streaming scoreboard
// for the CDB tag scheduler.
module tb_cdb_tag_scheduler;

  logic             clock;
  logic             reset;
  logic             flush;
  logic [3:0]       req_valid;
  logic [3:0][5:0]  req_tag;
  logic [3:0]       req_ready;
  logic [2:0]       cdb_enable;
  logic [2:0][5:0]  cdb_tag;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic            rst;
    logic            fl;
    logic [3:0]      rv;
    logic [3:0][5:0] tg;
    logic [3:0]      rdy;
    logic [2:0]      en;
    logic [2:0][5:0] ct;
  } vec_t;

  typedef struct packed {
    logic [5:0] tag;
    int         acc;
  } sb_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  sb_t  sb_q[$];

  cdb_tag_scheduler #(
    .NUM_REQ (4),
    .NUM_TAG (3),
    .TAG_SIZE(6)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_ready (req_ready),
    .cdb_enable(cdb_enable),
    .cdb_tag   (cdb_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic fl,
                              input logic [3:0] rv,
                              input logic [23:0] tg,
                              input logic [3:0] rdy,
                              input logic [2:0] en,
                              input logic [17:0] ct);
    vec_t v;
    v.rst = rst; v.fl = fl; v.rv = rv; v.tg = tg;
    v.rdy = rdy; v.en = en; v.ct = ct;
    return v;
  endfunction

  task automatic run_vec(input int n, input vec_t v);
    vec_t e;
    reset     = v.rst;
    flush     = v.fl;
    req_valid = v.rv;
    req_tag   = v.tg;
    exp_q.push_back(v);
    #2;
    chk($sformatf("v%0d req_ready", n), 64'(req_ready), 64'(v.rdy));
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    chk($sformatf("v%0d cdb_enable", n), 64'(cdb_enable), 64'(e.en));
    chk($sformatf("v%0d cdb_tag", n), 64'(cdb_tag), 64'(e.ct));
  endtask

  initial begin
    logic [5:0] z;
    int         nbc;
    bit         hit;
    z = 6'h00;

    // Vectors start right after reset release: rr_ptr=0, nothing pending.
    tbl.push_back(mk(1,0,4'b0000,{z,z,z,z},4'b1111,3'b000,{z,z,z}));
    tbl.push_back(mk(1,0,4'b0100,{z,6'h15,z,z},4'b1111,3'b000,{z,z,z}));
    tbl.push_back(mk(1,0,4'b0000,{z,z,z,z},4'b1111,3'b001,{z,z,6'h15}));
    tbl.push_back(mk(1,0,4'b0000,{z,z,z,z},4'b1111,3'b000,{z,z,z}));
    tbl.push_back(mk(1,0,4'b1000,{6'h3f,z,z,z},4'b1111,3'b000,{z,z,z}));
    tbl.push_back(mk(1,0,4'b0000,{z,z,z,z},4'b1111,3'b001,{z,z,6'h3f}));
    // Contention: all four pending with rr_ptr=0.
    tbl.push_back(mk(1,0,4'b1111,{6'h04,6'h03,6'h02,6'h01},4'b1111,3'b000,{z,z,z}));
    tbl.push_back(mk(1,0,4'b1111,{6'h08,6'h07,6'h06,6'h05},4'b0111,3'b111,{6'h03,6'h02,6'h01}));
    tbl.push_back(mk(1,0,4'b0000,{z,z,z,z},4'b1011,3'b111,{6'h06,6'h05,6'h04}));
    tbl.push_back(mk(1,0,4'b0000,{z,z,z,z},4'b1111,3'b001,{z,z,6'h07}));
    // Wrap-around from rr_ptr=3.
    tbl.push_back(mk(1,0,4'b1001,{6'h0b,z,z,6'h0a},4'b1111,3'b000,{z,z,z}));
    tbl.push_back(mk(1,0,4'b0000,{z,z,z,z},4'b1111,3'b011,{z,6'h0a,6'h0b}));
    tbl.push_back(mk(1,0,4'b0011,{z,z,6'h12,6'h21},4'b1111,3'b000,{z,z,z}));
    tbl.push_back(mk(1,0,4'b0000,{z,z,z,z},4'b1111,3'b011,{z,6'h21,6'h12}));
    // Flush with pending tags and a live broadcast.
    tbl.push_back(mk(1,0,4'b0111,{z,6'h33,6'h32,6'h31},4'b1111,3'b000,{z,z,z}));
    tbl.push_back(mk(1,0,4'b1111,{6'h38,6'h37,6'h36,6'h35},4'b1111,3'b111,{6'h31,6'h33,6'h32}));
    tbl.push_back(mk(1,1,4'b1111,{6'h01,6'h02,6'h03,6'h04},4'b0000,3'b000,{z,z,z}));
    tbl.push_back(mk(1,0,4'b0000,{z,z,z,z},4'b1111,3'b000,{z,z,z}));
    tbl.push_back(mk(1,0,4'b0011,{z,z,6'h1b,6'h1a},4'b1111,3'b000,{z,z,z}));
    tbl.push_back(mk(1,0,4'b0000,{z,z,z,z},4'b1111,3'b011,{z,6'h1a,6'h1b}));
    // Reset mid-operation drops the pending tag.
    tbl.push_back(mk(1,0,4'b0100,{z,6'h2c,z,z},4'b1111,3'b000,{z,z,z}));
    tbl.push_back(mk(0,0,4'b1111,{6'h03,6'h02,6'h01,6'h2c},4'b0000,3'b000,{z,z,z}));
    tbl.push_back(mk(1,0,4'b0000,{z,z,z,z},4'b1111,3'b000,{z,z,z}));
    // Tag 0 is legal and duplicates broadcast twice.
    tbl.push_back(mk(1,0,4'b0111,{z,6'h09,6'h09,z},4'b1111,3'b000,{z,z,z}));
    tbl.push_back(mk(1,0,4'b0000,{z,z,z,z},4'b1111,3'b111,{6'h09,6'h09,z}));

    reset     = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    req_tag   = '0;

    for (int c = 0; c < 2; c++) begin
      req_valid = 4'($urandom);
      req_tag   = 24'($urandom);
      #2;
      chk($sformatf("rst%0d req_ready", c), 64'(req_ready), 64'(0));
      @(posedge clock);
      #1;
      chk($sformatf("rst%0d cdb_enable", c), 64'(cdb_enable), 64'(0));
      chk($sformatf("rst%0d cdb_tag", c), 64'(cdb_tag), 64'(0));
    end

    foreach (tbl[n])
      run_vec(n, tbl[n]);

    // Streaming: FU1 offers a tag every cycle for 10 cycles.
    nbc = 0;
    for (int c = 0; c < 12; c++) begin
      reset     = 1'b1;
      flush     = 1'b0;
      req_valid = (c < 10) ? 4'b0010 : 4'b0000;
      req_tag   = {z, z, 6'(6'h20 + c), z};
      #2;
      if (c < 10)
        chk($sformatf("s%0d ready1", c), 64'(req_ready[1]), 64'(1));
      if (req_valid[1] && req_ready[1])
        sb_q.push_back('{tag: 6'(6'h20 + c), acc: c});
      @(posedge clock);
      #1;
      hit = (sb_q.size() > 0) && (sb_q[0].acc == c - 1);
      chk($sformatf("s%0d cdb_enable", c), 64'(cdb_enable),
          64'(hit ? 3'b001 : 3'b000));
      if (hit) begin
        chk($sformatf("s%0d cdb_tag0", c), 64'(cdb_tag[0]),
            64'(sb_q[0].tag));
        void'(sb_q.pop_front());
        nbc++;
      end
    end
    chk("stream left", 64'(sb_q.size()), 64'(0));
    chk("stream count", 64'(nbc), 64'(10));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
